// File: rtl/divider_pkg.sv
// divider_pkg
//   Shared definitions for the sequential restoring divider.
//   state_t : FSM state encoding (IDLE / BUSY / DONE).
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : divider_pkg

// File: rtl/divider.sv
// divider
//   Sequential restoring (shift-subtract) unsigned divider. One quotient bit
//   is produced per clock, MSB first, so a division takes exactly M cycles
//   after the start edge.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset (aborts any division)
//   en         in   1  level start/hold request
//   dividend   in   M  unsigned dividend, sampled at the start edge only
//   divisor    in   N  unsigned divisor, sampled at the start edge only
//   quotient   out  M  floor(dividend / divisor); all ones for divisor 0
//   divider_ok out  1  high while quotient holds a finished result
module divider
  import divider_pkg::*;
#(
  parameter int M = 26,
  parameter int N = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [M-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [M-1:0] quotient,
  output logic         divider_ok
);

  localparam int                CNT_W    = $clog2(M + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(M - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [M-1:0]       r_dvd;          // dividend, shifted left each BUSY cycle
  logic [M-1:0]       w_dvd_next;
  logic [N-1:0]       r_dvs;          // divisor latched at start
  logic [N-1:0]       w_dvs_next;
  logic [N:0]         r_rem;          // partial remainder
  logic [N:0]         w_rem_next;
  logic [M-1:0]       r_quotient;     // quotient shift register
  logic [M-1:0]       w_quotient_next;
  logic [CNT_W-1:0]   r_cnt;          // BUSY cycle counter
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_ok;
  logic               w_ok_next;

  // Datapath for one restoring step. The compare/subtract runs at N+1 bits
  // so the shifted remainder never overflows. r_rem[N] is always 0 after a
  // step (remainder < divisor), but if it were set the shifted value would
  // exceed any N-bit divisor, so OR-ing it into the compare keeps the step
  // correct for every register value.
  logic [N:0]         w_shift;
  logic [N:0]         w_dvs_ext;
  logic [N:0]         w_diff;
  logic               w_ge;

  assign w_shift   = {r_rem[N-1:0], r_dvd[M-1]};
  assign w_dvs_ext = {1'b0, r_dvs};
  assign w_diff    = w_shift - w_dvs_ext;
  assign w_ge      = r_rem[N] | (w_shift >= w_dvs_ext);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_next    = r_state;
    w_dvd_next      = r_dvd;
    w_dvs_next      = r_dvs;
    w_rem_next      = r_rem;
    w_quotient_next = r_quotient;
    w_cnt_next      = r_cnt;
    w_ok_next       = r_ok;

    case (r_state)
      IDLE: begin
        w_ok_next = 1'b0;
        if (en) begin
          w_dvd_next      = dividend;
          w_dvs_next      = divisor;
          w_rem_next      = '0;
          w_quotient_next = '0;
          w_cnt_next      = '0;
          w_state_next    = BUSY;
        end
      end

      BUSY: begin
        // en is ignored here: a started division always completes.
        // A zero divisor makes every compare succeed, giving all ones.
        w_rem_next      = w_ge ? w_diff : w_shift;
        w_dvd_next      = r_dvd << 1;
        w_quotient_next = (r_quotient << 1) | M'(w_ge);
        w_cnt_next      = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_ok_next    = 1'b1;
          w_state_next = DONE;
        end
      end

      DONE: begin
        if (!en) begin
          w_ok_next    = 1'b0;
          w_state_next = IDLE;
        end
      end

      default: begin
        w_ok_next    = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_quotient <= '0;
      r_cnt      <= '0;
      r_ok       <= 1'b0;
    end else begin
      r_dvd      <= w_dvd_next;
      r_dvs      <= w_dvs_next;
      r_rem      <= w_rem_next;
      r_quotient <= w_quotient_next;
      r_cnt      <= w_cnt_next;
      r_ok       <= w_ok_next;
    end
  end

  assign quotient   = r_quotient;
  assign divider_ok = r_ok;

endmodule : divider

// File: tb/tb_divider.sv
// tb_divider
//   Self-checking bench for divider: table-driven directed vectors, hand
//   sequences for reset/abort, operand change, early en release, and a
//   randomized operand sweep against a reference quotient.
module tb_divider;

  localparam int M       = 26;
  localparam int N       = 14;
  localparam int LAT_MAX = 60;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [M-1:0] dividend;
  logic [N-1:0] divisor;
  logic [M-1:0] quotient;
  logic         divider_ok;

  always #5 clk = ~clk;

  divider #(.M(M), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .divider_ok (divider_ok)
  );

  typedef struct {
    logic [M-1:0] a;
    logic [N-1:0] b;
    logic [M-1:0] q;
  } vec_t;

  vec_t vecs [12];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Drive operands with en=1, let the start edge pass, return at the
  // following falling edge (one BUSY edge still ahead of operand changes).
  task automatic start_op(input logic [M-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    en       = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count rising edges until divider_ok, starting at the negedge after the
  // start edge. Bounded so a stuck DUT cannot hang the run.
  task automatic wait_ok(output int lat);
    lat = 0;
    while (!divider_ok && lat < LAT_MAX) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Hold en high in DONE, verify the result is stable, then release en and
  // verify divider_ok falls on the next edge while quotient is kept.
  task automatic finish_op(input string tag, input logic [M-1:0] exp_q);
    repeat (5) @(negedge clk);
    check({tag, "_hold_ok"}, 64'(divider_ok), 64'(1));
    check({tag, "_hold_q"},  64'(quotient),   64'(exp_q));
    en = 1'b0;
    @(negedge clk);
    check({tag, "_drop_ok"}, 64'(divider_ok), 64'(0));
    check({tag, "_drop_q"},  64'(quotient),   64'(exp_q));
  endtask

  task automatic run_vec(input string tag, input logic [M-1:0] a,
                         input logic [N-1:0] b, input logic [M-1:0] exp_q);
    int lat;
    start_op(a, b);
    wait_ok(lat);
    $display("%s: %0d / %0d -> %0d (exp %0d) latency %0d", tag, a, b, quotient, exp_q, lat);
    check({tag, "_latency"},  64'(lat),      64'(M));
    check({tag, "_quotient"}, 64'(quotient), 64'(exp_q));
    finish_op(tag, exp_q);
  endtask

  initial begin
    int           lat;
    logic [M-1:0] ra;
    logic [N-1:0] rb;
    logic [M-1:0] rq;
    logic [M-1:0] ones;

    ones = '1;

    vecs[0]  = '{a: 26'd41254912, b: 14'd2891,  q: 26'd14270};
    vecs[1]  = '{a: 26'd100,      b: 14'd7,     q: 26'd14};
    vecs[2]  = '{a: 26'd5,        b: 14'd9,     q: 26'd0};
    vecs[3]  = '{a: 26'd12345,    b: 14'd0,     q: 26'h3FFFFFF};
    vecs[4]  = '{a: 26'h3FFFFFF,  b: 14'd1,     q: 26'h3FFFFFF};
    vecs[5]  = '{a: 26'h3FFFFFF,  b: 14'h3FFF,  q: 26'd4096};
    vecs[6]  = '{a: 26'd0,        b: 14'd5,     q: 26'd0};
    vecs[7]  = '{a: 26'd16383,    b: 14'd16383, q: 26'd1};
    vecs[8]  = '{a: 26'd1000000,  b: 14'd1000,  q: 26'd1000};
    vecs[9]  = '{a: 26'h3FFFFFF,  b: 14'd2,     q: 26'd33554431};
    vecs[10] = '{a: 26'd0,        b: 14'd0,     q: 26'h3FFFFFF};
    vecs[11] = '{a: 26'd999999,   b: 14'd3,     q: 26'd333333};

    // Reset state
    rst      = 1'b1;
    en       = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset_ok", 64'(divider_ok), 64'(0));
    check("reset_q",  64'(quotient),   64'(0));
    rst = 1'b0;

    // Idle with en low: nothing happens
    repeat (5) @(negedge clk);
    check("idle_ok", 64'(divider_ok), 64'(0));
    check("idle_q",  64'(quotient),   64'(0));

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q);
    end

    // Reset on BUSY cycle 10 aborts with no result
    start_op(26'd100, 14'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ok", 64'(divider_ok), 64'(0));
    check("abort_q",  64'(quotient),   64'(0));
    rst = 1'b0;
    en  = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_idle_ok", 64'(divider_ok), 64'(0));
    check("abort_idle_q",  64'(quotient),   64'(0));

    // First start right as reset is released: rst=0 and en=1 on one edge
    rst      = 1'b1;
    en       = 1'b1;
    dividend = 26'd41254912;
    divisor  = 14'd2891;
    @(negedge clk);
    check("rst_en_ok", 64'(divider_ok), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wait_ok(lat);
    $display("restart: 41254912 / 2891 -> %0d latency %0d", quotient, lat);
    check("restart_latency",  64'(lat),      64'(M));
    check("restart_quotient", 64'(quotient), 64'(14270));
    finish_op("restart", 26'd14270);

    // Operands changed after the start edge must not matter
    start_op(26'd41254912, 14'd2891);
    dividend = 26'd5;
    divisor  = 14'd9;
    wait_ok(lat);
    $display("opchange: 41254912 / 2891 -> %0d latency %0d", quotient, lat);
    check("opchange_latency",  64'(lat),      64'(M));
    check("opchange_quotient", 64'(quotient), 64'(14270));
    finish_op("opchange", 26'd14270);

    // en dropped mid-BUSY: result still delivered, then cleared next edge
    start_op(26'd1000000, 14'd1000);
    lat = 0;
    while (!divider_ok && lat < LAT_MAX) begin
      if (lat == 5) en = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    $display("endrop: 1000000 / 1000 -> %0d latency %0d", quotient, lat);
    check("endrop_latency",  64'(lat),      64'(M));
    check("endrop_quotient", 64'(quotient), 64'(1000));
    @(negedge clk);
    check("endrop_fall_ok", 64'(divider_ok), 64'(0));
    check("endrop_fall_q",  64'(quotient),   64'(1000));
    repeat (5) @(negedge clk);
    check("endrop_idle_ok", 64'(divider_ok), 64'(0));

    // Random sweep against floor division
    for (int i = 0; i < 1000; i++) begin
      ra = M'($urandom());
      if (i % 4 == 0) rb = N'($urandom_range(0, 15));
      else            rb = N'($urandom());
      rq = (rb == 0) ? ones : ra / M'(rb);
      run_vec($sformatf("rnd%0d", i), ra, rb, rq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_divider

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter M, default 26: dividend and quotient width in bits.
REQ-002 Parameter N, default 14: divisor width in bits.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  level-sensitive start/hold request.
REQ-006 dividend  input  M  unsigned dividend; sampled only at start.
REQ-007 divisor  input  N  unsigned divisor; sampled only at start.
REQ-008 quotient  output  M  unsigned quotient floor(dividend/divisor); registered.
REQ-009 divider_ok  output  1  high while quotient holds a valid result; registered.

Function
REQ-010 Algorithm SHALL be sequential restoring (shift-subtract) division, one quotient bit per clock, MSB first.
REQ-011 FSM states SHALL be IDLE, BUSY and DONE.
REQ-012 IDLE, en=1 at a rising edge: latch dividend and divisor, clear the partial remainder (N+1 bits) and the bit counter, clear quotient and divider_ok, go to BUSY.
REQ-013 IDLE, en=0: stay in IDLE, divider_ok=0, quotient keeps its last value.
REQ-014 Each BUSY cycle: remainder = {remainder, next dividend MSB}; if remainder >= divisor, subtract the divisor and shift in quotient bit 1, else shift in 0.
REQ-015 BUSY SHALL last exactly M cycles; on the M-th BUSY edge, go to DONE with the final quotient and divider_ok=1.
REQ-016 Latency: divider_ok rises exactly M rising edges after the edge that sampled en=1 in IDLE (26 cycles by default).
REQ-017 DONE: quotient and divider_ok SHALL hold while en=1; no restart occurs while en stays high.
REQ-018 DONE, en=0: go to IDLE and clear divider_ok on that edge; quotient keeps its value.
REQ-019 en deasserted during BUSY SHALL NOT abort the operation; the result is delivered and held until en=0 is seen in DONE.
REQ-020 Changes on dividend or divisor after the start edge SHALL NOT affect the result in progress.
REQ-021 Divisor zero: quotient SHALL be all ones, with normal latency and divider_ok=1.
REQ-022 Internal compare/subtract width SHALL be N+1 bits so that no overflow occurs for any operand values.

Reset
REQ-023 rst=1 at a rising edge: state=IDLE, quotient=0, divider_ok=0, remainder and counter=0.
REQ-024 rst SHALL take priority over en, including mid-BUSY, which aborts the operation with no result.
REQ-025 First start after rst is released: rst=0 and en=1 on the same edge.

Structure
REQ-026 State encoding (IDLE/BUSY/DONE) SHALL reside in a shared package divider_pkg; M and N remain module parameters.
REQ-027 No sub-module is needed; the block is one FSM plus a datapath (remainder, quotient shift register, counter of width clog2(M+1)).

Verification
REQ-028 dividend=0x9D6<<14 (41254912), divisor=0x0B4B (2891), en held high -> after 26 cycles divider_ok=1, quotient=14270 (0x37BE), both held stable.
REQ-029 dividend=100, divisor=7 -> quotient=14; dividend=5, divisor=9 -> quotient=0.
REQ-030 divisor=0, dividend=12345 -> quotient=0x3FFFFFF, divider_ok=1 after 26 cycles.
REQ-031 rst pulsed on cycle 10 of BUSY -> divider_ok stays 0, quotient=0; a new start with en=1 completes in 26 cycles.
REQ-032 Operands changed one cycle after the start edge -> result matches the originally latched operands; en dropped in DONE -> divider_ok falls on the next edge.
REQ-033 Random sweep of 1000 operand pairs -> quotient equals floor(dividend/divisor), latency is always exactly M.
